register_bank: RTL and testbench
================================

Name: register_bank

Overview:
- Parametrised successor to the single load-enable register.
- Holds NUM_REGS registers of WIDTH bits each, behind one write/modify port and two asynchronous read ports.
- The write/modify port supports eight register operations: load, increment, decrement, shifts, rotate and clear.
- Produces carry and zero flags and is gated by the global clk_en. Serves as the CPU's general-purpose/pointer register bank (B, C, temp, stack pointer).

Parameters:
- WIDTH, 16, bit width of each register.
- NUM_REGS, 4, number of registers (2..16; need not be a power of two).
- IDX_W, $clog2(NUM_REGS) (min 1), select width; derived, not overridden.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- i_reset  input  1  synchronous, active-high reset.
- clk_en  input  1  global clock enable; when low, no register or flag state changes (reset excepted).
- i_op  input  3  operation code, see Behaviour.
- i_wr_sel  input  IDX_W  index of the register the operation acts on.
- i_wr_data  input  WIDTH  data for LOAD.
- i_rd_sel_a  input  IDX_W  read port A index.
- i_rd_sel_b  input  IDX_W  read port B index.
- o_rd_data_a  output  WIDTH  contents of register i_rd_sel_a.
- o_rd_data_b  output  WIDTH  contents of register i_rd_sel_b.
- o_carry  output  1  carry/borrow/shifted-out bit of the last executed operation.
- o_zero  output  1  high when the result of the last executed operation was zero.

Behaviour:
- Single clock domain. Reset is synchronous and active-high and takes priority over clk_en.
  - On reset: all registers = 0, o_carry = 0, o_zero = 0.
- Execution condition: an operation executes on a rising edge when clk_en = 1, i_reset = 0, i_op != NOP and i_wr_sel < NUM_REGS. Result, o_carry and o_zero update on that edge (latency 1).
- Op codes (R = selected register):
  - 000 NOP: no change; flags hold.
  - 001 LOAD: R <= i_wr_data; carry <= 0.
  - 010 INC: R <= R+1, modulo 2^WIDTH; carry <= 1 iff R was all-ones (wrap to 0).
  - 011 DEC: R <= R-1, modulo 2^WIDTH; carry (borrow) <= 1 iff R was 0 (wrap to all-ones).
  - 100 SHL: R <= {R[WIDTH-2:0],0}; carry <= R[WIDTH-1].
  - 101 SHR (logical): R <= {0,R[WIDTH-1:1]}; carry <= R[0].
  - 110 ROL: R <= {R[WIDTH-2:0],R[WIDTH-1]}; carry <= R[WIDTH-1].
  - 111 CLR: R <= 0; carry <= 0.
- Zero flag: o_zero <= (new R == 0) for every executed op.
- Out-of-range i_wr_sel (≥ NUM_REGS): operation ignored; registers and flags hold.
- Reads: combinational from register state.
  - Out-of-range read index returns 0.
  - A read of the register being modified in the same cycle returns the pre-edge value (no forwarding) unless the optional feature is enabled.
  - Both read ports may select the same register.
- clk_en low: all state holds, including while i_op is non-NOP.
- Reset asserted in the same cycle as an operation: reset wins; the operation is discarded.

Optional Feature:
- Macro: REGISTER_BANK_BYPASS_EN.
- Defined: a read port whose index equals i_wr_sel, while an operation would execute this cycle, returns the operation's result combinationally (write-through forwarding).
- Undefined: read ports always return stored (pre-edge) values.
- Flags are identical in both builds.

Decomposition:
- register_bank_pkg holds:
  - the 3-bit op-code constants: OP_NOP, OP_LOAD, OP_INC, OP_DEC, OP_SHL, OP_SHR, OP_ROL, OP_CLR;
  - a shared op-width constant.
- One sub-module, register_bank_alu: purely combinational. Inputs: operand, load data, op. Outputs: result, carry, zero. Instantiated once; its outputs feed both the write-back path and the optional bypass.

Test Plan:
- Reset → all reads 0, o_carry=0, o_zero=0. Then LOAD r2=0x1234 with clk_en=1 → next cycle o_rd_data_a(sel 2)=0x1234, zero=0, carry=0.
- LOAD r1=0xFFFF, then INC r1 → r1=0x0000, carry=1, zero=1. Then DEC r1 → r1=0xFFFF, carry=1, zero=0.
- LOAD r0=0x8001; SHL → 0x0002, carry=1. SHR → 0x0001, carry=0. ROL from 0x8001 → 0x0003, carry=1.
- INC r3 presented with clk_en=0 for 3 cycles → r3 and flags unchanged. Same op with clk_en=1 → r3 +1 after one edge.
- NUM_REGS=3: LOAD to index 3 → no register or flag changes. Read index 3 → 0.
- LOAD r0=0xAAAA with i_reset=1 in the same cycle → r0=0. With REGISTER_BANK_BYPASS_EN: LOAD r1=0x5555 while reading r1 → same-cycle read shows 0x5555 (0x0000 without the macro).

Source files
------------

// File: rtl/register_bank_pkg.sv
// Shared op-code constants for the register bank and its ALU.
package register_bank_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_NOP  = 3'b000;
  localparam logic [OP_W-1:0] OP_LOAD = 3'b001;
  localparam logic [OP_W-1:0] OP_INC  = 3'b010;
  localparam logic [OP_W-1:0] OP_DEC  = 3'b011;
  localparam logic [OP_W-1:0] OP_SHL  = 3'b100;
  localparam logic [OP_W-1:0] OP_SHR  = 3'b101;
  localparam logic [OP_W-1:0] OP_ROL  = 3'b110;
  localparam logic [OP_W-1:0] OP_CLR  = 3'b111;

endpackage

// File: rtl/register_bank_alu.sv
// Combinational operation unit: computes the new register value plus carry and zero.
module register_bank_alu
  import register_bank_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_operand,
  input  logic [WIDTH-1:0] i_load_data,
  input  logic [OP_W-1:0]  i_op,
  output logic [WIDTH-1:0] o_result,
  output logic             o_carry,
  output logic             o_zero
);

  // Result and carry per op; NOP passes the operand through.
  always_comb begin
    o_result = i_operand;
    o_carry  = 1'b0;
    case (i_op)
      OP_LOAD: o_result = i_load_data;
      OP_INC:  {o_carry, o_result} = {1'b0, i_operand} + {{WIDTH{1'b0}}, 1'b1};
      OP_DEC: begin
        o_result = i_operand - {{(WIDTH-1){1'b0}}, 1'b1};
        o_carry  = (i_operand == {WIDTH{1'b0}});
      end
      OP_SHL: begin
        o_result = {i_operand[WIDTH-2:0], 1'b0};
        o_carry  = i_operand[WIDTH-1];
      end
      OP_SHR: begin
        o_result = {1'b0, i_operand[WIDTH-1:1]};
        o_carry  = i_operand[0];
      end
      OP_ROL: begin
        o_result = {i_operand[WIDTH-2:0], i_operand[WIDTH-1]};
        o_carry  = i_operand[WIDTH-1];
      end
      OP_CLR:  o_result = {WIDTH{1'b0}};
      default: o_result = i_operand;
    endcase
    o_zero = (o_result == {WIDTH{1'b0}});
  end

endmodule

// File: rtl/register_bank.sv
// NUM_REGS x WIDTH register bank with one modify port and two combinational read ports.
// Define REGISTER_BANK_BYPASS_EN to forward the in-flight result onto matching read ports.
module register_bank
  import register_bank_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int NUM_REGS = 4,
  localparam int IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic             clk,
  input  logic             i_reset,
  input  logic             clk_en,
  input  logic [OP_W-1:0]  i_op,
  input  logic [IDX_W-1:0] i_wr_sel,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic [IDX_W-1:0] i_rd_sel_a,
  input  logic [IDX_W-1:0] i_rd_sel_b,
  output logic [WIDTH-1:0] o_rd_data_a,
  output logic [WIDTH-1:0] o_rd_data_b,
  output logic             o_carry,
  output logic             o_zero
);

  localparam logic [IDX_W:0] SEL_LIMIT = (IDX_W+1)'(NUM_REGS);

  logic [WIDTH-1:0] regs_q [NUM_REGS];
  logic [WIDTH-1:0] regs_d [NUM_REGS];
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] operand_s;
  logic [WIDTH-1:0] alu_result_s;
  logic             alu_carry_s;
  logic             alu_zero_s;
  logic             exec_s;

  assign exec_s = clk_en && !i_reset && (i_op != OP_NOP) && ({1'b0, i_wr_sel} < SEL_LIMIT);

  // Operand fetch for the selected register.
  always_comb begin
    operand_s = {WIDTH{1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      operand_s = (i_wr_sel == IDX_W'(i)) ? regs_q[i] : operand_s;
    end
  end

  register_bank_alu #(.WIDTH(WIDTH)) u_alu (
    .i_operand   (operand_s),
    .i_load_data (i_wr_data),
    .i_op        (i_op),
    .o_result    (alu_result_s),
    .o_carry     (alu_carry_s),
    .o_zero      (alu_zero_s)
  );

  // Next-state: only the selected register and the flags change on an executed op.
  always_comb begin
    carry_d = exec_s ? alu_carry_s : carry_q;
    zero_d  = exec_s ? alu_zero_s  : zero_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = (exec_s && (i_wr_sel == IDX_W'(i))) ? alu_result_s : regs_q[i];
    end
  end

  // State registers; reset has priority over everything else.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= {WIDTH{1'b0}};
      end
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end

  // Read ports; indices with no backing register read as zero.
  always_comb begin
    o_rd_data_a = {WIDTH{1'b0}};
    o_rd_data_b = {WIDTH{1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      o_rd_data_a = (i_rd_sel_a == IDX_W'(i)) ? regs_q[i] : o_rd_data_a;
      o_rd_data_b = (i_rd_sel_b == IDX_W'(i)) ? regs_q[i] : o_rd_data_b;
    end
`ifdef REGISTER_BANK_BYPASS_EN
    o_rd_data_a = (exec_s && (i_rd_sel_a == i_wr_sel)) ? alu_result_s : o_rd_data_a;
    o_rd_data_b = (exec_s && (i_rd_sel_b == i_wr_sel)) ? alu_result_s : o_rd_data_b;
`else
    o_rd_data_a = o_rd_data_a;
    o_rd_data_b = o_rd_data_b;
`endif
  end

  assign o_carry = carry_q;
  assign o_zero  = zero_q;

endmodule

// File: tb/tb_register_bank.sv
// Directed self-checking bench for register_bank (4-register and 3-register instances).
module tb_register_bank;
  import register_bank_pkg::*;

  logic        clk;
  logic        i_reset;
  logic        clk_en;
  logic [2:0]  i_op;
  logic [1:0]  i_wr_sel;
  logic [15:0] i_wr_data;
  logic [1:0]  i_rd_sel_a;
  logic [1:0]  i_rd_sel_b;
  logic [15:0] rd_a, rd_b, rd3_a, rd3_b;
  logic        carry, zero, carry3, zero3;

  int checks = 0;
  int errors = 0;

  register_bank #(.WIDTH(16), .NUM_REGS(4)) dut (
    .clk(clk), .i_reset(i_reset), .clk_en(clk_en), .i_op(i_op),
    .i_wr_sel(i_wr_sel), .i_wr_data(i_wr_data),
    .i_rd_sel_a(i_rd_sel_a), .i_rd_sel_b(i_rd_sel_b),
    .o_rd_data_a(rd_a), .o_rd_data_b(rd_b), .o_carry(carry), .o_zero(zero)
  );

  register_bank #(.WIDTH(16), .NUM_REGS(3)) dut3 (
    .clk(clk), .i_reset(i_reset), .clk_en(clk_en), .i_op(i_op),
    .i_wr_sel(i_wr_sel), .i_wr_data(i_wr_data),
    .i_rd_sel_a(i_rd_sel_a), .i_rd_sel_b(i_rd_sel_b),
    .o_rd_data_a(rd3_a), .o_rd_data_b(rd3_b), .o_carry(carry3), .o_zero(zero3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one op for a single rising edge, then return to NOP.
  task automatic step(input logic [2:0] op, input logic [1:0] sel, input logic [15:0] data);
    i_op = op; i_wr_sel = sel; i_wr_data = data;
    @(posedge clk);
    #1;
    i_op = OP_NOP;
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    step(OP_LOAD, 2'd0, 16'hAAAA);
    step(OP_LOAD, 2'd1, 16'h5555);
    i_reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      i_rd_sel_a = 2'(i); i_rd_sel_b = 2'(i);
      #1;
      checks++; if (rd_a !== 16'h0000) begin errors++; $display("FAIL reset_rd_a[%0d] got %h exp 0000", i, rd_a); end
      checks++; if (rd_b !== 16'h0000) begin errors++; $display("FAIL reset_rd_b[%0d] got %h exp 0000", i, rd_b); end
      checks++; if (rd3_a !== 16'h0000) begin errors++; $display("FAIL reset3_rd_a[%0d] got %h exp 0000", i, rd3_a); end
    end
    checks++; if (carry !== 1'b0 || zero !== 1'b0) begin errors++; $display("FAIL reset_flags got c=%b z=%b exp c=0 z=0", carry, zero); end
    checks++; if (carry3 !== 1'b0 || zero3 !== 1'b0) begin errors++; $display("FAIL reset3_flags got c=%b z=%b exp c=0 z=0", carry3, zero3); end
  endtask

  task automatic test_load();
    i_rd_sel_a = 2'd2;
    step(OP_LOAD, 2'd2, 16'h1234);
    checks++; if (rd_a !== 16'h1234) begin errors++; $display("FAIL load_r2 got %h exp 1234", rd_a); end
    checks++; if (carry !== 1'b0 || zero !== 1'b0) begin errors++; $display("FAIL load_flags got c=%b z=%b exp c=0 z=0", carry, zero); end
  endtask

  task automatic test_inc_dec();
    i_rd_sel_b = 2'd1;
    step(OP_LOAD, 2'd1, 16'hFFFF);
    checks++; if (rd_b !== 16'hFFFF) begin errors++; $display("FAIL load_r1 got %h exp ffff", rd_b); end
    step(OP_INC, 2'd1, 16'h0000);
    checks++; if (rd_b !== 16'h0000) begin errors++; $display("FAIL inc_wrap got %h exp 0000", rd_b); end
    checks++; if (carry !== 1'b1 || zero !== 1'b1) begin errors++; $display("FAIL inc_flags got c=%b z=%b exp c=1 z=1", carry, zero); end
    step(OP_DEC, 2'd1, 16'h0000);
    checks++; if (rd_b !== 16'hFFFF) begin errors++; $display("FAIL dec_wrap got %h exp ffff", rd_b); end
    checks++; if (carry !== 1'b1 || zero !== 1'b0) begin errors++; $display("FAIL dec_flags got c=%b z=%b exp c=1 z=0", carry, zero); end
    step(OP_DEC, 2'd1, 16'h0000);
    checks++; if (rd_b !== 16'hFFFE || carry !== 1'b0) begin errors++; $display("FAIL dec_plain got %h c=%b exp fffe c=0", rd_b, carry); end
  endtask

  task automatic test_shift();
    i_rd_sel_a = 2'd0;
    step(OP_LOAD, 2'd0, 16'h8001);
    step(OP_SHL, 2'd0, 16'h0000);
    checks++; if (rd_a !== 16'h0002 || carry !== 1'b1 || zero !== 1'b0) begin errors++; $display("FAIL shl got %h c=%b z=%b exp 0002 c=1 z=0", rd_a, carry, zero); end
    step(OP_SHR, 2'd0, 16'h0000);
    checks++; if (rd_a !== 16'h0001 || carry !== 1'b0) begin errors++; $display("FAIL shr got %h c=%b exp 0001 c=0", rd_a, carry); end
    step(OP_SHR, 2'd0, 16'h0000);
    checks++; if (rd_a !== 16'h0000 || carry !== 1'b1 || zero !== 1'b1) begin errors++; $display("FAIL shr_out got %h c=%b z=%b exp 0000 c=1 z=1", rd_a, carry, zero); end
    step(OP_LOAD, 2'd0, 16'h8001);
    step(OP_ROL, 2'd0, 16'h0000);
    checks++; if (rd_a !== 16'h0003 || carry !== 1'b1 || zero !== 1'b0) begin errors++; $display("FAIL rol got %h c=%b z=%b exp 0003 c=1 z=0", rd_a, carry, zero); end
    step(OP_CLR, 2'd0, 16'h0000);
    checks++; if (rd_a !== 16'h0000 || carry !== 1'b0 || zero !== 1'b1) begin errors++; $display("FAIL clr got %h c=%b z=%b exp 0000 c=0 z=1", rd_a, carry, zero); end
  endtask

  task automatic test_clk_en();
    i_rd_sel_a = 2'd3;
    step(OP_LOAD, 2'd3, 16'hFFFF);
    step(OP_INC, 2'd3, 16'h0000);
    clk_en = 1'b0;
    i_op = OP_INC; i_wr_sel = 2'd3;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++; if (rd_a !== 16'h0000 || carry !== 1'b1 || zero !== 1'b1) begin errors++; $display("FAIL clk_en_hold[%0d] got %h c=%b z=%b exp 0000 c=1 z=1", i, rd_a, carry, zero); end
    end
    clk_en = 1'b1;
    @(posedge clk); #1;
    i_op = OP_NOP;
    checks++; if (rd_a !== 16'h0001 || carry !== 1'b0 || zero !== 1'b0) begin errors++; $display("FAIL clk_en_resume got %h c=%b z=%b exp 0001 c=0 z=0", rd_a, carry, zero); end
  endtask

  task automatic test_out_of_range();
    step(OP_LOAD, 2'd2, 16'h0000);
    step(OP_LOAD, 2'd3, 16'hBEEF);
    i_rd_sel_a = 2'd3; i_rd_sel_b = 2'd2;
    #1;
    checks++; if (rd3_a !== 16'h0000) begin errors++; $display("FAIL oor_read got %h exp 0000", rd3_a); end
    checks++; if (rd3_b !== 16'h0000) begin errors++; $display("FAIL oor_r2 got %h exp 0000", rd3_b); end
    checks++; if (carry3 !== 1'b0 || zero3 !== 1'b1) begin errors++; $display("FAIL oor_flags got c=%b z=%b exp c=0 z=1", carry3, zero3); end
    checks++; if (rd_a !== 16'hBEEF || zero !== 1'b0) begin errors++; $display("FAIL r3_in_range got %h z=%b exp beef z=0", rd_a, zero); end
  endtask

  task automatic test_reset_wins();
    i_rd_sel_a = 2'd0;
    step(OP_LOAD, 2'd0, 16'h1111);
    checks++; if (rd_a !== 16'h1111) begin errors++; $display("FAIL pre_reset got %h exp 1111", rd_a); end
    i_reset = 1'b1;
    step(OP_LOAD, 2'd0, 16'hAAAA);
    i_reset = 1'b0;
    checks++; if (rd_a !== 16'h0000 || carry !== 1'b0 || zero !== 1'b0) begin errors++; $display("FAIL reset_wins got %h c=%b z=%b exp 0000 c=0 z=0", rd_a, carry, zero); end
  endtask

  task automatic test_bypass();
    logic [15:0] exp_same;
`ifdef REGISTER_BANK_BYPASS_EN
    exp_same = 16'h5555;
`else
    exp_same = 16'h0000;
`endif
    i_rd_sel_a = 2'd1; i_rd_sel_b = 2'd0;
    i_op = OP_LOAD; i_wr_sel = 2'd1; i_wr_data = 16'h5555;
    #1;
    checks++; if (rd_a !== exp_same) begin errors++; $display("FAIL bypass_same got %h exp %h", rd_a, exp_same); end
    checks++; if (rd_b !== 16'h0000) begin errors++; $display("FAIL bypass_other got %h exp 0000", rd_b); end
    @(posedge clk); #1;
    i_op = OP_NOP;
    checks++; if (rd_a !== 16'h5555) begin errors++; $display("FAIL bypass_after got %h exp 5555", rd_a); end
  endtask

  initial begin
    i_reset = 1'b1; clk_en = 1'b1; i_op = OP_NOP;
    i_wr_sel = 2'd0; i_wr_data = 16'h0000;
    i_rd_sel_a = 2'd0; i_rd_sel_b = 2'd0;
    @(posedge clk); #1;
    test_reset();
    test_load();
    test_inc_dec();
    test_shift();
    test_clk_en();
    test_out_of_range();
    test_reset_wins();
    test_bypass();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
